// File: rtl/keys_pio_master_if.sv
// Avalon-MM bus to the KEY edge-capture PIO slave plus the key-event stream.
interface keys_pio_master_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        event_valid;
  logic        event_ready;
  logic [3:0]  event_edges;
  logic [3:0]  event_level;

  modport master (
    output address, chipselect, write_n, writedata, event_valid, event_edges, event_level,
    input  readdata, irq, event_ready
  );

  modport slave (
    input  address, chipselect, write_n, writedata, event_valid, event_edges, event_level,
    output readdata, irq, event_ready
  );
endinterface

// File: rtl/keys_pio_master.sv
// Hardware service loop for the KEY PIO: init the slave, then on irq read and clear the
// edge captures, sample key levels and hand one event downstream.
module keys_pio_master #(
  parameter logic [3:0]  IRQ_MASK = 4'hF,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  keys_pio_master_if.master  bus,
  output logic [COUNT_W-1:0] press_count
);

  typedef enum logic [2:0] {
    StInitMask,
    StInitClr,
    StIdle,
    StRdEdge,
    StClr,
    StRdLvl,
    StLatchLvl,
    StEmit
  } state_e;

  state_e             state_q, state_d;
  logic               init_hold_q;
  logic [3:0]         edges_q, edges_d;
  logic [3:0]         level_q, level_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // init_hold_q keeps the bus quiet while reset is held; the mask write starts on the first
  // cycle after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StInitMask;
      init_hold_q <= 1'b1;
      edges_q     <= 4'b0;
      level_q     <= 4'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_hold_q <= 1'b0;
      edges_q     <= edges_d;
      level_q     <= level_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    edges_d         = edges_q;
    level_d         = level_q;
    count_d         = count_q;
    bus.chipselect  = 1'b0;
    bus.write_n     = 1'b1;
    bus.address     = 2'd0;
    bus.writedata   = 32'b0;
    bus.event_valid = 1'b0;

    unique case (state_q)
      StInitMask: begin
        if (!init_hold_q) begin
          bus.chipselect = 1'b1;
          bus.write_n    = 1'b0;
          bus.address    = 2'd2;
          bus.writedata  = {28'b0, IRQ_MASK};
          state_d        = StInitClr;
        end
      end
      StInitClr: begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 2'd3;
        state_d        = StIdle;
      end
      StIdle: begin
        if (bus.irq && enable) state_d = StRdEdge;
      end
      StRdEdge: begin
        bus.chipselect = 1'b1;
        bus.address    = 2'd3;
        state_d        = StClr;
      end
      StClr: begin
        // Read data from StRdEdge arrives now; clear the captures in the same cycle.
        edges_d        = bus.readdata[3:0] & IRQ_MASK;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 2'd3;
        state_d        = StRdLvl;
      end
      StRdLvl: begin
        bus.chipselect = 1'b1;
        bus.address    = 2'd0;
        state_d        = StLatchLvl;
      end
      StLatchLvl: begin
        level_d = bus.readdata[3:0];
        state_d = (edges_q != 4'b0) ? StEmit : StIdle;
      end
      StEmit: begin
        bus.event_valid = 1'b1;
        if (bus.event_ready) begin
          count_d = count_q + COUNT_W'(1);
          state_d = StIdle;
        end
      end
    endcase
  end

  assign bus.event_edges = edges_q;
  assign bus.event_level = level_q;
  assign press_count     = count_q;

endmodule

// File: tb/tb_keys_pio_master.sv
// Bench for keys_pio_master: two DUTs (default and narrow mask/counter) on behavioural
// edge-capture PIO slaves, with a queue of expected events per DUT.
module tb_keys_pio_master;

  logic clk = 1'b0;
  logic reset;
  logic en_a, en_b;
  logic [15:0] pc_a;
  logic [1:0]  pc_b;

  always #5 clk = ~clk;

  keys_pio_master_if bus_a ();
  keys_pio_master_if bus_b ();

  keys_pio_master dut_a (
    .clk        (clk),
    .reset      (reset),
    .enable     (en_a),
    .bus        (bus_a),
    .press_count(pc_a)
  );

  keys_pio_master #(
    .IRQ_MASK(4'b0011),
    .COUNT_W (2)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .enable     (en_b),
    .bus        (bus_b),
    .press_count(pc_b)
  );

  // Slave models: registered read data (latency 1), any write to address 3 clears captures.
  logic [3:0] ec_a, msk_a, inj_a, lvl_a;
  logic [3:0] ec_b, msk_b, inj_b, lvl_b;
  logic       frc_a, frc_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      ec_a <= 4'b0;
      msk_a <= 4'b0;
      bus_a.readdata <= 32'b0;
    end else begin
      if (bus_a.chipselect && bus_a.write_n)
        bus_a.readdata <= (bus_a.address == 2'd0) ? {28'b0, lvl_a} :
                          (bus_a.address == 2'd2) ? {28'b0, msk_a} :
                          (bus_a.address == 2'd3) ? {28'b0, ec_a} : 32'b0;
      if (bus_a.chipselect && !bus_a.write_n && bus_a.address == 2'd2)
        msk_a <= bus_a.writedata[3:0];
      if (bus_a.chipselect && !bus_a.write_n && bus_a.address == 2'd3) ec_a <= 4'b0;
      else ec_a <= ec_a | inj_a;
    end
  end
  assign bus_a.irq = (|(ec_a & msk_a)) | frc_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      ec_b <= 4'b0;
      msk_b <= 4'b0;
      bus_b.readdata <= 32'b0;
    end else begin
      if (bus_b.chipselect && bus_b.write_n)
        bus_b.readdata <= (bus_b.address == 2'd0) ? {28'b0, lvl_b} :
                          (bus_b.address == 2'd2) ? {28'b0, msk_b} :
                          (bus_b.address == 2'd3) ? {28'b0, ec_b} : 32'b0;
      if (bus_b.chipselect && !bus_b.write_n && bus_b.address == 2'd2)
        msk_b <= bus_b.writedata[3:0];
      if (bus_b.chipselect && !bus_b.write_n && bus_b.address == 2'd3) ec_b <= 4'b0;
      else ec_b <= ec_b | inj_b;
    end
  end
  assign bus_b.irq = (|(ec_b & msk_b)) | frc_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] exp_ev;

  task automatic inject_a(input logic [3:0] edges, input logic [3:0] level);
    @(negedge clk);
    lvl_a = level;
    inj_a = edges;
    qa.push_back({edges, level});
    @(negedge clk);
    inj_a = 4'b0;
  endtask

  task automatic inject_b(input logic [3:0] edges, input logic [3:0] level);
    @(negedge clk);
    lvl_b = level;
    inj_b = edges;
    qb.push_back({edges, level});
    @(negedge clk);
    inj_b = 4'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus_a.chipselect, bus_a.write_n, bus_a.address} !== 4'b0100 || bus_a.writedata !== 32'b0)
    begin
      n_fail++;
      $display("FAIL reset_bus: got cs=%b wn=%b addr=%0d wd=%h, want cs=0 wn=1 addr=0 wd=0",
               bus_a.chipselect, bus_a.write_n, bus_a.address, bus_a.writedata);
    end
    n_checks++;
    if ({bus_a.event_valid, bus_a.event_edges, bus_a.event_level} !== 9'b0 || pc_a !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_event: got v=%b e=%b l=%b pc=%0d, want all 0", bus_a.event_valid,
               bus_a.event_edges, bus_a.event_level, pc_a);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_a.chipselect, bus_a.write_n, bus_a.address} !== 4'b1010 || bus_a.writedata !== 32'hF)
    begin
      n_fail++;
      $display("FAIL init_mask_a: got cs=%b wn=%b addr=%0d wd=%h, want cs=1 wn=0 addr=2 wd=f",
               bus_a.chipselect, bus_a.write_n, bus_a.address, bus_a.writedata);
    end
    n_checks++;
    if (bus_b.chipselect !== 1'b1 || bus_b.writedata !== 32'h3) begin
      n_fail++;
      $display("FAIL init_mask_b: got cs=%b wd=%h, want cs=1 wd=3", bus_b.chipselect,
               bus_b.writedata);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_a.chipselect, bus_a.write_n, bus_a.address} !== 4'b1011 || bus_a.writedata !== 32'b0)
    begin
      n_fail++;
      $display("FAIL init_clr: got cs=%b wn=%b addr=%0d wd=%h, want cs=1 wn=0 addr=3 wd=0",
               bus_a.chipselect, bus_a.write_n, bus_a.address, bus_a.writedata);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_a.chipselect, bus_a.write_n, bus_a.address} !== 4'b0100 || bus_a.event_valid !== 1'b0
        || pc_a !== 16'd0) begin
      n_fail++;
      $display("FAIL init_idle: got cs=%b wn=%b addr=%0d v=%b pc=%0d, want cs=0 wn=1 addr=0 v=0 pc=0",
               bus_a.chipselect, bus_a.write_n, bus_a.address, bus_a.event_valid, pc_a);
    end
  endtask

  task automatic test_single_event();
    inject_a(4'b0100, 4'b1011);
    @(negedge clk);
    n_checks++;
    if ({bus_a.chipselect, bus_a.write_n, bus_a.address} !== 4'b1111) begin
      n_fail++;
      $display("FAIL rd_edge: got cs=%b wn=%b addr=%0d, want cs=1 wn=1 addr=3",
               bus_a.chipselect, bus_a.write_n, bus_a.address);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_a.chipselect, bus_a.write_n, bus_a.address} !== 4'b1011 || bus_a.writedata !== 32'b0)
    begin
      n_fail++;
      $display("FAIL clr_write: got cs=%b wn=%b addr=%0d wd=%h, want cs=1 wn=0 addr=3 wd=0",
               bus_a.chipselect, bus_a.write_n, bus_a.address, bus_a.writedata);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_a.chipselect, bus_a.write_n, bus_a.address} !== 4'b1100 || bus_a.irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_lvl: got cs=%b wn=%b addr=%0d irq=%b, want cs=1 wn=1 addr=0 irq=0",
               bus_a.chipselect, bus_a.write_n, bus_a.address, bus_a.irq);
    end
    @(negedge clk);
    n_checks++;
    if (bus_a.chipselect !== 1'b0 || bus_a.event_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latch_lvl: got cs=%b v=%b, want cs=0 v=0", bus_a.chipselect,
               bus_a.event_valid);
    end
    @(negedge clk);
    exp_ev = qa.pop_front();
    n_checks++;
    if (bus_a.event_valid !== 1'b1 || {bus_a.event_edges, bus_a.event_level} !== exp_ev) begin
      n_fail++;
      $display("FAIL emit_event: got v=%b e=%b l=%b, want v=1 e=%b l=%b", bus_a.event_valid,
               bus_a.event_edges, bus_a.event_level, exp_ev[7:4], exp_ev[3:0]);
    end
    @(negedge clk);
    n_checks++;
    if (bus_a.event_valid !== 1'b0 || pc_a !== 16'd1) begin
      n_fail++;
      $display("FAIL single_count: got v=%b pc=%0d, want v=0 pc=1", bus_a.event_valid, pc_a);
    end
  endtask

  task automatic test_backpressure();
    logic found;
    bus_a.event_ready = 1'b0;
    inject_a(4'b0001, 4'b1110);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus_a.event_valid;
    end
    exp_ev = qa.pop_front();
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL bp_timeout: got no event_valid in 20 cycles, want event_valid");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus_a.event_valid !== 1'b1 || {bus_a.event_edges, bus_a.event_level} !== exp_ev ||
          bus_a.chipselect !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b e=%b l=%b cs=%b, want v=1 e=%b l=%b cs=0", i,
                 bus_a.event_valid, bus_a.event_edges, bus_a.event_level, bus_a.chipselect,
                 exp_ev[7:4], exp_ev[3:0]);
      end
    end
    bus_a.event_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_a.event_valid !== 1'b0 || pc_a !== 16'd2) begin
      n_fail++;
      $display("FAIL bp_accept: got v=%b pc=%0d, want v=0 pc=2", bus_a.event_valid, pc_a);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (pc_a !== 16'd2 || bus_a.chipselect !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_once: got pc=%0d cs=%b, want pc=2 cs=0", pc_a, bus_a.chipselect);
    end
  endtask

  task automatic test_enable();
    logic found;
    en_a = 1'b0;
    inject_a(4'b0010, 4'b0111);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus_a.chipselect !== 1'b0 || bus_a.event_valid !== 1'b0 || bus_a.irq !== 1'b1) begin
        n_fail++;
        $display("FAIL en_hold[%0d]: got cs=%b v=%b irq=%b, want cs=0 v=0 irq=1", i,
                 bus_a.chipselect, bus_a.event_valid, bus_a.irq);
      end
    end
    en_a = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus_a.chipselect, bus_a.write_n, bus_a.address} !== 4'b1111) begin
      n_fail++;
      $display("FAIL en_start: got cs=%b wn=%b addr=%0d, want cs=1 wn=1 addr=3",
               bus_a.chipselect, bus_a.write_n, bus_a.address);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus_a.event_valid;
    end
    exp_ev = qa.pop_front();
    n_checks++;
    if (!found || {bus_a.event_edges, bus_a.event_level} !== exp_ev) begin
      n_fail++;
      $display("FAIL en_event: got v=%b e=%b l=%b, want v=1 e=%b l=%b", found,
               bus_a.event_edges, bus_a.event_level, exp_ev[7:4], exp_ev[3:0]);
    end
    @(negedge clk);
    n_checks++;
    if (pc_a !== 16'd3) begin
      n_fail++;
      $display("FAIL en_count: got pc=%0d, want pc=3", pc_a);
    end
  endtask

  task automatic test_wrap();
    logic found;
    for (int k = 0; k < 5; k++) begin
      inject_b((k % 2 == 1) ? 4'b0010 : 4'b0001, 4'(k + 3));
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        found = bus_b.event_valid;
      end
      exp_ev = qb.pop_front();
      n_checks++;
      if (!found || {bus_b.event_edges, bus_b.event_level} !== exp_ev) begin
        n_fail++;
        $display("FAIL wrap_event[%0d]: got v=%b e=%b l=%b, want v=1 e=%b l=%b", k, found,
                 bus_b.event_edges, bus_b.event_level, exp_ev[7:4], exp_ev[3:0]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (pc_b !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap_count: got pc=%0d, want pc=1", pc_b);
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    lvl_b = 4'b1010;
    inj_b = 4'b1100;
    frc_b = 1'b1;
    @(negedge clk);
    inj_b = 4'b0;
    frc_b = 1'b0;
    n_checks++;
    if ({bus_b.chipselect, bus_b.write_n, bus_b.address} !== 4'b1111) begin
      n_fail++;
      $display("FAIL spur_start: got cs=%b wn=%b addr=%0d, want cs=1 wn=1 addr=3",
               bus_b.chipselect, bus_b.write_n, bus_b.address);
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus_b.event_valid !== 1'b0 || bus_b.chipselect !== 1'b0 || bus_b.event_edges !== 4'b0 ||
          pc_b !== 2'd1) begin
        n_fail++;
        $display("FAIL spur_idle[%0d]: got v=%b cs=%b e=%b pc=%0d, want v=0 cs=0 e=0000 pc=1", i,
                 bus_b.event_valid, bus_b.chipselect, bus_b.event_edges, pc_b);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_emit();
    logic found;
    bus_a.event_ready = 1'b0;
    inject_a(4'b1000, 4'b0101);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus_a.event_valid;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_emit_wait: got no event_valid in 20 cycles, want event_valid");
    end
    reset = 1'b1;
    @(negedge clk);
    qa.delete();
    n_checks++;
    if (bus_a.event_valid !== 1'b0 || pc_a !== 16'd0 || bus_a.chipselect !== 1'b0 ||
        bus_a.event_edges !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_emit: got v=%b pc=%0d cs=%b e=%b, want v=0 pc=0 cs=0 e=0000",
               bus_a.event_valid, pc_a, bus_a.chipselect, bus_a.event_edges);
    end
    reset = 1'b0;
    bus_a.event_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus_a.chipselect, bus_a.write_n, bus_a.address} !== 4'b1010 || bus_a.writedata !== 32'hF)
    begin
      n_fail++;
      $display("FAIL rst_reinit_mask: got cs=%b wn=%b addr=%0d wd=%h, want cs=1 wn=0 addr=2 wd=f",
               bus_a.chipselect, bus_a.write_n, bus_a.address, bus_a.writedata);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_a.chipselect, bus_a.write_n, bus_a.address} !== 4'b1011) begin
      n_fail++;
      $display("FAIL rst_reinit_clr: got cs=%b wn=%b addr=%0d, want cs=1 wn=0 addr=3",
               bus_a.chipselect, bus_a.write_n, bus_a.address);
    end
  endtask

  initial begin
    reset = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    bus_a.event_ready = 1'b1;
    bus_b.event_ready = 1'b1;
    inj_a = 4'b0;
    inj_b = 4'b0;
    lvl_a = 4'hF;
    lvl_b = 4'hF;
    frc_a = 1'b0;
    frc_b = 1'b0;
    test_reset();
    test_single_event();
    test_backpressure();
    test_enable();
    test_wrap();
    test_spurious();
    test_reset_in_emit();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, want finish");
    $fatal(1);
  end

endmodule
